// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin issue of N_REQ requesters onto one shared pipelined multiplier.
// Optional feature macro: MULT_SCHED_REDUX_EN (forward per-request reduction select).

module mult_scheduler #(
    parameter int BIT_LENGTH = 256,
    parameter int N_REQ      = 4,
    parameter int MULT_LAT   = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*BIT_LENGTH-1:0] req_a,
    input  logic [N_REQ*BIT_LENGTH-1:0] req_b,
    input  logic [N_REQ-1:0]            req_redux,
    output logic [BIT_LENGTH-1:0]       mult_A,
    output logic [BIT_LENGTH-1:0]       mult_B,
    output logic                        mult_redux,
    input  logic [2*BIT_LENGTH-1:0]     mult_C,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [2*BIT_LENGTH-1:0]     rsp_data,
    output logic                        busy
);

    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [N_REQ-1:0]                wait_q, wait_d;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [MULT_LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [MULT_LAT-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;
    logic                            busy_q, busy_d;

    logic [N_REQ-1:0]                eligible_s;
    logic                            grant_vld_s;
    logic [IDX_W-1:0]                grant_idx_s;
    logic [IDX_W:0]                  cand_s;
    logic [N_REQ-1:0]                rsp_hit_s;

`ifdef MULT_SCHED_REDUX_EN
    // Redux is consumed one stage before the response, so its pipeline is one stage shorter.
    logic [MULT_LAT-2:0]             tag_rdx_q, tag_rdx_d;
`else
    logic                            unused_redux_s;
    assign unused_redux_s = ^req_redux;
`endif

    // Round-robin arbitration: first eligible index at or after rr_ptr_q, wrapping.
    always_comb begin
        eligible_s  = (rst || !en) ? {N_REQ{1'b0}} : (req_valid & ~wait_q);
        grant_vld_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        cand_s      = {(IDX_W+1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand_s >= N_REQ_W) begin
                cand_s = cand_s - N_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_vld_s && eligible_s[cand_s[IDX_W-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s[IDX_W-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Issue-side and response-side outputs.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        mult_A    = {BIT_LENGTH{1'b0}};
        mult_B    = {BIT_LENGTH{1'b0}};
        rsp_hit_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vld_s && (grant_idx_s == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
                mult_A       = req_a[i*BIT_LENGTH +: BIT_LENGTH];
                mult_B       = req_b[i*BIT_LENGTH +: BIT_LENGTH];
            end else begin
                req_ready[i] = 1'b0;
            end
            rsp_hit_s[i] = !rst && tag_vld_q[MULT_LAT-1] && (tag_idx_q[MULT_LAT-1] == IDX_W'(i));
        end
        rsp_valid = rsp_hit_s;
        rsp_data  = (|rsp_hit_s) ? mult_C : {(2*BIT_LENGTH){1'b0}};
`ifdef MULT_SCHED_REDUX_EN
        mult_redux = !rst && tag_rdx_q[MULT_LAT-2];
`else
        mult_redux = 1'b0;
`endif
    end

    // Next state: requester WAIT flags, pointer, tag shift (empty slots included).
    always_comb begin
        wait_d       = (wait_q & ~rsp_hit_s) | req_ready;
        rr_ptr_d     = grant_vld_s ? ((grant_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : (grant_idx_s + ONE_IDX))
                                   : rr_ptr_q;
        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = grant_vld_s;
        tag_idx_d[0] = grant_idx_s;
        for (int k = 1; k < MULT_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end
`ifdef MULT_SCHED_REDUX_EN
        tag_rdx_d    = tag_rdx_q;
        tag_rdx_d[0] = grant_vld_s && req_redux[grant_idx_s];
        for (int k = 1; k < MULT_LAT-1; k++) begin
            tag_rdx_d[k] = tag_rdx_q[k-1];
        end
`endif
        busy_d = |wait_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= {N_REQ{1'b0}};
            rr_ptr_q  <= {IDX_W{1'b0}};
            tag_vld_q <= {MULT_LAT{1'b0}};
            tag_idx_q <= '0;
            busy_q    <= 1'b0;
`ifdef MULT_SCHED_REDUX_EN
            tag_rdx_q <= {(MULT_LAT-1){1'b0}};
`endif
        end else begin
            wait_q    <= wait_d;
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
            busy_q    <= busy_d;
`ifdef MULT_SCHED_REDUX_EN
            tag_rdx_q <= tag_rdx_d;
`endif
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: directed table, hand sequences and a
// randomized phase scored against a per-requester transaction model.

module tb_mult_scheduler;

    localparam int BL  = 32;
    localparam int N   = 4;
    localparam int LAT = 6;

    logic             clk = 1'b0;
    logic             rst, en;
    logic [N-1:0]     req_valid, req_ready, req_redux, rsp_valid;
    logic [N*BL-1:0]  req_a, req_b;
    logic [BL-1:0]    mult_A, mult_B;
    logic             mult_redux, busy;
    logic [2*BL-1:0]  mult_C, rsp_data;

    mult_scheduler #(.BIT_LENGTH(BL), .N_REQ(N), .MULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_redux(req_redux),
        .mult_A(mult_A), .mult_B(mult_B), .mult_redux(mult_redux), .mult_C(mult_C),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product appears LAT cycles after operands.
    logic [2*BL-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= (2*BL)'(mult_A) * (2*BL)'(mult_B);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_C = mpipe[LAT-1];

    // Transaction model
    logic [N-1:0]    m_out;
    int              m_due  [N];
    logic [2*BL-1:0] m_prod [N];
    bit              m_rdx  [N];
    int              m_start, m_grant, cyc;
    int              n_cmp, n_err;

    // Values sampled at the falling edge
    logic [N-1:0]    s_ready, s_rv;
    logic [2*BL-1:0] s_rd;
    logic [BL-1:0]   s_mA, s_mB;
    logic            s_busy, s_redux;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0]    elig, exp_rdy, exp_rv;
        logic [2*BL-1:0] exp_rd;
        logic [BL-1:0]   exp_a, exp_b;
        bit              exp_rdx;
        int              g;
        @(negedge clk);
        s_ready = req_ready; s_rv = rsp_valid; s_rd = rsp_data;
        s_mA = mult_A; s_mB = mult_B; s_busy = busy; s_redux = mult_redux;
        g = -1;
        if (!rst) begin
            elig = en ? (req_valid & ~m_out) : '0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_start + k) % N;
                if (g < 0 && elig[j]) g = j;
            end
            exp_rdy = '0; exp_a = '0; exp_b = '0;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                exp_a = req_a[g*BL +: BL];
                exp_b = req_b[g*BL +: BL];
            end
            exp_rv = '0; exp_rd = '0; exp_rdx = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_out[i] && m_due[i] == cyc) begin
                    exp_rv[i] = 1'b1;
                    exp_rd    = m_prod[i];
                end
`ifdef MULT_SCHED_REDUX_EN
                if (m_out[i] && m_due[i] == cyc + 1 && m_rdx[i]) exp_rdx = 1'b1;
`endif
            end
            chk("req_ready",  s_ready, exp_rdy);
            chk("mult_A",     s_mA,    exp_a);
            chk("mult_B",     s_mB,    exp_b);
            chk("rsp_valid",  s_rv,    exp_rv);
            chk("rsp_data",   s_rd,    exp_rd);
            chk("busy",       s_busy,  |m_out);
            chk("mult_redux", s_redux, exp_rdx);
            for (int i = 0; i < N; i++)
                if (m_out[i] && m_due[i] == cyc) m_out[i] = 1'b0;
            if (g >= 0) begin
                m_out[g]  = 1'b1;
                m_due[g]  = cyc + LAT;
                m_prod[g] = (2*BL)'(req_a[g*BL +: BL]) * (2*BL)'(req_b[g*BL +: BL]);
                m_rdx[g]  = req_redux[g];
                m_start   = (g + 1) % N;
            end
        end else begin
            m_out   = '0;
            m_start = 0;
        end
        m_grant = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_rsp_valid", s_rv, 0);
        chk("rst_rsp_data", s_rd, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_mult_A", s_mA, 0);
        chk("rst_mult_redux", s_redux, 0);
        rst = 1'b0;
        req_valid = '0;
    endtask

    typedef struct {
        int              idx;
        logic [BL-1:0]   a;
        logic [BL-1:0]   b;
        logic            redux;
        logic [2*BL-1:0] prod;
        logic [N-1:0]    onehot;
    } vec_t;

    vec_t tbl [4];
    logic [N-1:0] seen;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; m_out = '0; m_start = 0; m_grant = -1;
        rst = 1'b1; en = 1'b1; req_redux = '0;
        req_a = '0; req_b = '0;
        req_valid = '1;
        #1;
        tbl[0] = '{2, 32'd3, 32'd5, 1'b1, 64'd15, 4'b0100};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 4'b0001};
        tbl[2] = '{3, 32'd0, 32'd123, 1'b1, 64'd0, 4'b1000};
        tbl[3] = '{1, 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 4'b0010};

        do_reset();

        // Directed single requests with known products and full latency
        for (int v = 0; v < 4; v++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            req_a[tbl[v].idx*BL +: BL] = tbl[v].a;
            req_b[tbl[v].idx*BL +: BL] = tbl[v].b;
            req_redux = '0;
            req_redux[tbl[v].idx] = tbl[v].redux;
            req_valid = tbl[v].onehot;
            tick();
            chk("tbl_grant", s_ready, tbl[v].onehot);
            req_valid = '0;
            repeat (5) tick();
            tick();
            chk("tbl_rsp_valid", s_rv, tbl[v].onehot);
            chk("tbl_rsp_data", s_rd, tbl[v].prod);
            tick();
            chk("tbl_idle_busy", s_busy, 1'b0);
        end

        // All four from reset: grants 0..3, responses 6..9 cycles later
        do_reset();
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", s_ready, 4'b0001 << k);
            req_valid[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_rsp", s_rv, 4'b0001 << k);
        end
        tick();

        // Requester 1 holds valid while waiting; others still served
        do_reset();
        req_valid = 4'b0010;
        tick();
        chk("reassert_first", s_ready, 4'b0010);
        req_valid = 4'b1010;
        tick();
        chk("reassert_other", s_ready, 4'b1000);
        req_valid = 4'b0010;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("reassert_blocked", s_ready, 4'b0000);
        end
        chk("reassert_rsp", s_rv, 4'b0010);
        tick();
        chk("reassert_regrant", s_ready, 4'b0010);
        req_valid = '0;
        repeat (8) tick();

        // Reset three cycles after an issue discards it
        do_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_rsp", s_rv, 4'b0000);
            chk("post_rst_busy", s_busy, 1'b0);
        end

        // en low: no new grants, in-flight work drains
        do_reset();
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0010;
        tick();
        en = 1'b0;
        req_valid = 4'b1100;
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("en_low_ready", s_ready, 4'b0000);
            seen = seen | s_rv;
        end
        chk("en_low_rsp_seen", seen, 4'b0011);
        chk("en_low_busy", s_busy, 1'b0);
        en = 1'b1;
        tick();
        chk("en_resume", s_ready, 4'b0100);
        req_valid = '0;
        repeat (8) tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && m_grant == i) begin
                    req_valid[i] = $urandom_range(0, 1) != 0;
                    req_a[i*BL +: BL] = $urandom;
                    req_b[i*BL +: BL] = $urandom;
                    req_redux[i] = $urandom_range(0, 1) != 0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*BL +: BL] = $urandom;
                    req_b[i*BL +: BL] = $urandom;
                    req_redux[i] = $urandom_range(0, 1) != 0;
                end
            end
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 SHALL provide parameter BIT_LENGTH, default 256, operand width of the shared multiplier.
REQ-002 SHALL provide parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL provide parameter MULT_LAT, default 6, cycles from operand presentation to product on mult_C.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset, also forwarded to the multiplier
- en  in  1  issue enable; low blocks new issues, in-flight work drains
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_a  in  N_REQ*BIT_LENGTH  operand A, requester i at slice i
- req_b  in  N_REQ*BIT_LENGTH  operand B, requester i at slice i
- req_redux  in  N_REQ  per-request reduction option
- mult_A  out  BIT_LENGTH  multiplier operand A
- mult_B  out  BIT_LENGTH  multiplier operand B
- mult_redux  out  1  multiplier reduction select
- mult_C  in  2*BIT_LENGTH  multiplier product
- rsp_valid  out  N_REQ  one-hot, single-cycle response strobe
- rsp_data  out  2*BIT_LENGTH  product for the strobed requester
- busy  out  1  any request outstanding

Function
REQ-006 Handshake: a request transfers when req_valid[i] & req_ready[i] are both high at a rising edge.
REQ-007 Each requester SHALL have at most one outstanding request. Per-requester state: IDLE -> WAIT on transfer; WAIT -> IDLE in the cycle its rsp_valid is high.
REQ-008 Eligible set: req_valid[i] & state[i]==IDLE & en. At most one grant per cycle.
REQ-009 Arbitration SHALL be round-robin. Search starts at the index after the last granted requester. The pointer updates only on a transfer. After reset the pointer starts at index 0.
REQ-010 req_ready SHALL be combinational from the eligible set and the pointer, with no dependency on rsp_valid in the same cycle.
REQ-011 On a transfer in cycle t, mult_A and mult_B SHALL carry the granted operands during cycle t, unregistered. In cycles with no transfer they SHALL be all zeros.
REQ-012 A tag pipeline of depth MULT_LAT SHALL carry {valid, index, redux} for each issue slot, including empty slots.
REQ-013 mult_redux SHALL be high during cycle t+MULT_LAT-1 iff the issue at t had redux set. This aligns it with the multiplier's final-stage sampling. Otherwise mult_redux is low.
REQ-014 In cycle t+MULT_LAT: rsp_data SHALL equal mult_C and rsp_valid SHALL be one-hot on the issuing index. Latency is exactly MULT_LAT cycles, request to response.
REQ-015 rsp_data SHALL be zero whenever rsp_valid is zero.
REQ-016 The multiplier's valid output SHALL be ignored; timing comes solely from the tag pipeline. Fill cycles after reset therefore produce no response.
REQ-017 Back-to-back issues from different requesters in consecutive cycles SHALL be supported. Throughput is one product per cycle.
REQ-018 A requester whose response strobes in cycle t SHALL NOT be granted in cycle t; it is eligible from t+1.
REQ-019 Deasserting en SHALL NOT affect in-flight tags. busy SHALL stay high until the last response strobes.
REQ-020 Requests not granted SHALL be held by the requester. The scheduler does not buffer operands.

Reset
REQ-021 On rst: all states go to IDLE, the tag pipeline clears, the pointer goes to 0, and req_ready, rsp_valid, rsp_data, mult_redux and busy go to 0. mult_A and mult_B go to zero.
REQ-022 Reset mid-operation SHALL discard all in-flight work. No response is issued for requests accepted before reset.

Configuration
REQ-023 Macro MULT_SCHED_REDUX_EN, when defined: req_redux is honoured per REQ-013.
REQ-024 Without MULT_SCHED_REDUX_EN: req_redux is ignored, the tag pipeline omits the redux bit, and mult_redux is tied 0.

Verification
REQ-025 Single request: requester 2, a=3, b=5, issued at cycle 10 -> rsp_valid=4'b0100 and rsp_data=15 at cycle 16. Only requester 2 sees a strobe.
REQ-026 All four requesting from reset -> grants in order 0,1,2,3 on consecutive cycles, then responses in the same order at cycles +6..+9.
REQ-027 Requester 1 re-asserts immediately after its transfer -> req_ready[1] low until one cycle after its response. Others are granted meanwhile.
REQ-028 With REDUX_EN, requester 0 redux=1 issued at t -> mult_redux high only at t+5. Without the macro, mult_redux is never high.
REQ-029 rst asserted 3 cycles after an issue -> no rsp_valid for 10 cycles after reset release, busy=0.
REQ-030 en low with two requests in flight -> no new req_ready, both responses delivered, then busy=0.
